// File: rtl/code_playback.sv
// code_playback
//
// Replays a stored code as timed lamp flashes. On start, snapshots four 7-entry
// button vectors and a clamped entry count, then for each entry lights the
// matching lamps for ON_CYCLES cycles followed by OFF_CYCLES blank cycles.
//
// Optional feature macro: PLAYBACK_ABORT_EN (adds the abort input).
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   abort         stop playback (only with PLAYBACK_ABORT_EN)
//   start         request playback, sampled only in IDLE
//   len           entry count, clamped to 7
//   slot1..slot4  per-button entry vectors, bit i = entry i
//   led           lamp drives, led[0] = button 1
//   busy          high while entries are being shown
//   done          one-cycle pulse after the last gap
//   idx           entry currently shown
module code_playback #(
   parameter int unsigned ON_CYCLES  = 4,
   parameter int unsigned OFF_CYCLES = 2,
   parameter int unsigned CNT_W      = 4
) (
   input  logic             clk,
   input  logic             reset,
`ifdef PLAYBACK_ABORT_EN
   input  logic             abort,
`endif
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic [6:0]       slot1,
   input  logic [6:0]       slot2,
   input  logic [6:0]       slot3,
   input  logic [6:0]       slot4,
   output logic [3:0]       led,
   output logic             busy,
   output logic             done,
   output logic [2:0]       idx
);

   localparam int unsigned MaxCyc = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int unsigned TmrW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
   localparam logic [TmrW-1:0] OnLast  = TmrW'(ON_CYCLES - 1);
   localparam logic [TmrW-1:0] OffLast = TmrW'(OFF_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StOn, StOff, StDone} state_e;

   state_e            state_q, state_d;
   logic [TmrW-1:0]   tmr_q, tmr_d;
   logic [2:0]        idx_q, idx_d;
   logic [2:0]        len_q, len_d;
   logic [6:0]        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d;
   logic [2:0]        len_clamp;
   logic [3:0]        led_next;
   logic              abort_hit;

   // Output registers; they trail the state register by one cycle so that
   // lamps appear the cycle after the start edge.
   logic [3:0]        led_q;
   logic              busy_q, done_q;
   logic [2:0]        idx_out_q;

   assign led  = led_q;
   assign busy = busy_q;
   assign done = done_q;
   assign idx  = idx_out_q;

   always_comb begin
      len_clamp = (len > CNT_W'(7)) ? 3'd7 : len[2:0];
      led_next  = {s4_q[idx_q], s3_q[idx_q], s2_q[idx_q], s1_q[idx_q]};
   end

`ifdef PLAYBACK_ABORT_EN
   // busy_q covers the trailing visible OFF cycle while the state is already DONE.
   always_comb begin
      abort_hit = abort && (state_q == StOn || state_q == StOff || busy_q);
   end
`else
   always_comb begin
      abort_hit = 1'b0;
   end
`endif

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      idx_d   = idx_q;
      len_d   = len_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      s3_d    = s3_q;
      s4_d    = s4_q;
      case (state_q)
         StIdle: begin
            // done_q high means the DONE cycle is still visible; restart waits.
            if (start && !done_q) begin
               len_d = len_clamp;
               s1_d  = slot1;
               s2_d  = slot2;
               s3_d  = slot3;
               s4_d  = slot4;
               idx_d = 3'd0;
               tmr_d = '0;
               state_d = (len_clamp == 3'd0) ? StDone : StOn;
            end
         end
         StOn: begin
            if (tmr_q == OnLast) begin
               tmr_d   = '0;
               state_d = StOff;
            end else begin
               tmr_d = tmr_q + TmrW'(1);
            end
         end
         StOff: begin
            if (tmr_q == OffLast) begin
               tmr_d = '0;
               if (idx_q == len_q - 3'd1) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = StOn;
               end
            end else begin
               tmr_d = tmr_q + TmrW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (abort_hit) begin
         state_d = StIdle;
         tmr_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         tmr_q   <= '0;
         idx_q   <= 3'd0;
         len_q   <= 3'd0;
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         s4_q    <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s3_q    <= s3_d;
         s4_q    <= s4_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_q     <= 4'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         idx_out_q <= 3'd0;
      end else begin
         led_q     <= (!abort_hit && state_q == StOn) ? led_next : 4'd0;
         busy_q    <= !abort_hit && (state_q == StOn || state_q == StOff);
         done_q    <= !abort_hit && (state_q == StDone);
         idx_out_q <= idx_q;
      end
   end

endmodule
